// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared state encoding, uop cond bit positions and result selection for div_sched
package div_sched_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN0 = 2'd1;
  localparam logic [1:0] S_RUN1 = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int DIV_REM = 0;
  localparam int DIV_SIGNED = 1;
  function automatic logic [31:0] pick(input logic rem, input logic [31:0] q, input logic [31:0] r);
    return rem ? r : q;
  endfunction
endpackage

// File: rtl/div_sched_lane.sv
// div_sched_lane: per-lane operand capture and result holding register
module div_sched_lane
  import div_sched_pkg::*;
(
  input  logic        clk,
  input  logic        aresetn,
  input  logic        cap,
  input  logic        clr,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic        req_rem,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  input  logic        wr,
  input  logic [31:0] core_q,
  input  logic [31:0] core_r,
  output logic        valid,
  output logic        sgn,
  output logic        rem,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] data,
  output logic [4:0]  rd
);
  // capture the request in IDLE; latch the result, zero divisor yields q=0 r=a without the core
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      valid <= 1'b0;
      sgn <= 1'b0;
      rem <= 1'b0;
      a <= '0;
      b <= '0;
      rd <= '0;
      data <= '0;
    end else begin
      if (clr) valid <= 1'b0;
      else if (cap) begin
        valid <= req_valid;
        sgn <= req_signed;
        rem <= req_rem;
        a <= req_a;
        b <= req_b;
        rd <= req_rd;
      end
      if (wr) data <= (b == '0) ? pick(rem, '0, a) : pick(rem, core_q, core_r);
    end
  end
endmodule

// File: rtl/div_sched.sv
// div_sched: serialises lane 0 / lane 1 divides onto one shared divider core and holds results for EX2/WB
module div_sched
  import div_sched_pkg::*;
#(
  parameter int REQ_W = 2
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic        req0_signed,
  input  logic        req1_signed,
  input  logic        req0_rem,
  input  logic        req1_rem,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req0_rd,
  input  logic [4:0]  req1_rd,
  output logic        core_start,
  output logic        core_abort,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic        core_signed,
  input  logic        core_done,
  input  logic [31:0] core_q,
  input  logic [31:0] core_r,
  output logic        stall_divider,
  output logic        div_ready,
  output logic        res0_valid,
  output logic        res1_valid,
  output logic [31:0] res0_data,
  output logic [31:0] res1_data,
  output logic [4:0]  res0_rd,
  output logic [4:0]  res1_rd,
  input  logic        accept
);
  logic [1:0] st;
  logic started;
  logic idle, run0, run1, run, done, sel, any_req, first, bz, done_ok, adv, cap, clr;
  logic [REQ_W-1:0] v, sg, rm;
  logic [31:0] la [REQ_W];
  logic [31:0] lb [REQ_W];
  logic [31:0] ld [REQ_W];
  logic [4:0] lrd [REQ_W];
  assign idle = st == S_IDLE;
  assign run0 = st == S_RUN0;
  assign run1 = st == S_RUN1;
  assign done = st == S_DONE;
  assign run = run0 | run1;
  assign sel = run1;
  assign any_req = req0_valid | req1_valid;
  assign first = run & ~started;
  assign bz = lb[sel] == '0;
  assign done_ok = run & started & core_done & ~flush;
  assign adv = run & ~flush & ((first & bz) | done_ok);
  assign cap = idle & any_req & ~flush;
  assign clr = flush | (done & accept);
  assign core_start = first & ~bz & ~flush;
  assign core_abort = run & started & flush & aresetn;
  assign core_a = la[sel];
  assign core_b = lb[sel];
  assign core_signed = sg[sel];
  assign stall_divider = (idle & any_req) | run;
  assign div_ready = done;
  assign res0_valid = done & v[0];
  assign res1_valid = done & v[1];
  assign res0_data = ld[0];
  assign res1_data = ld[1];
  assign res0_rd = lrd[0];
  assign res1_rd = lrd[1];
  generate
    for (genvar i = 0; i < REQ_W; i++) begin : g_lane
      div_sched_lane u_lane (
        .clk        (clk),
        .aresetn    (aresetn),
        .cap        (cap),
        .clr        (clr),
        .req_valid  (i == 0 ? req0_valid : req1_valid),
        .req_signed (i == 0 ? req0_signed : req1_signed),
        .req_rem    (i == 0 ? req0_rem : req1_rem),
        .req_a      (i == 0 ? req0_a : req1_a),
        .req_b      (i == 0 ? req0_b : req1_b),
        .req_rd     (i == 0 ? req0_rd : req1_rd),
        .wr         (adv & (i == 0 ? run0 : run1)),
        .core_q     (core_q),
        .core_r     (core_r),
        .valid      (v[i]),
        .sgn        (sg[i]),
        .rem        (rm[i]),
        .a          (la[i]),
        .b          (lb[i]),
        .data       (ld[i]),
        .rd         (lrd[i])
      );
    end
  endgenerate
  // sequencer: lane 0 runs before lane 1; started marks that the core holds the current op
  always_ff @(posedge clk) begin
    if (!aresetn || flush) begin
      st <= S_IDLE;
      started <= 1'b0;
    end else begin
      st <= (idle & any_req) ? (req0_valid ? S_RUN0 : S_RUN1) :
            (run0 & adv) ? (v[1] ? S_RUN1 : S_DONE) :
            (run1 & adv) ? S_DONE :
            (done & accept) ? S_IDLE : st;
      started <= adv ? 1'b0 : (core_start ? 1'b1 : started);
    end
  end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed and random checks of div_sched against a behavioural divider core and result model
module tb_div_sched;
  localparam int N = 33;
  logic clk = 0, aresetn = 0, flush = 0, accept = 0;
  logic req0_valid = 0, req1_valid = 0, req0_signed = 0, req1_signed = 0, req0_rem = 0, req1_rem = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [4:0] req0_rd = 0, req1_rd = 0;
  logic core_start, core_abort, core_signed, core_done;
  logic [31:0] core_a, core_b, core_q, core_r;
  logic stall_divider, div_ready, res0_valid, res1_valid;
  logic [31:0] res0_data, res1_data;
  logic [4:0] res0_rd, res1_rd;
  int checks = 0, failures = 0, cyc = 0, starts = 0, ovl = 0, ccnt = 0;
  logic cbusy = 0, inj = 0;
  logic [31:0] cq = 0, cr = 0;

  div_sched dut (
    .clk(clk), .aresetn(aresetn), .flush(flush),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_signed(req0_signed), .req1_signed(req1_signed),
    .req0_rem(req0_rem), .req1_rem(req1_rem),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_rd(req0_rd), .req1_rd(req1_rd),
    .core_start(core_start), .core_abort(core_abort),
    .core_a(core_a), .core_b(core_b), .core_signed(core_signed),
    .core_done(core_done), .core_q(core_q), .core_r(core_r),
    .stall_divider(stall_divider), .div_ready(div_ready),
    .res0_valid(res0_valid), .res1_valid(res1_valid),
    .res0_data(res0_data), .res1_data(res1_data),
    .res0_rd(res0_rd), .res1_rd(res1_rd),
    .accept(accept)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural divider core: done pulses N cycles after the start cycle, abort/reset cancel it
  assign core_done = (cbusy && ccnt == 1) || inj;
  assign core_q = cq;
  assign core_r = cr;
  always @(posedge clk) begin
    if (!aresetn || core_abort) cbusy <= 0;
    else if (core_start) begin
      if (cbusy) ovl <= ovl + 1;
      cbusy <= 1;
      ccnt <= N;
      starts <= starts + 1;
      cq <= core_signed ? 32'($signed(core_a) / $signed(core_b)) : core_a / core_b;
      cr <= core_signed ? 32'($signed(core_a) % $signed(core_b)) : core_a % core_b;
    end else if (cbusy) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) cbusy <= 0;
    end
  end

  function automatic logic [31:0] exp_res(input logic s, input logic r, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return r ? a : 32'd0;
    if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return r ? a % b : a / b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic v0, input logic v1, input logic s0, input logic s1, input logic r0, input logic r1,
                     input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] a1, input logic [31:0] b1,
                     input logic [4:0] d0, input logic [4:0] d1, input int hold);
    int t, lat0, lat1, st_exp, st_seen, bad, s0n, nst;
    logic got;
    logic [31:0] e0, e1, fa;
    lat0 = v0 ? (b0 == 0 ? 1 : N + 1) : 0;
    lat1 = v1 ? (b1 == 0 ? 1 : N + 1) : 0;
    st_exp = (v0 && b0 != 0) ? 1 : (v1 && b1 != 0) ? 1 + lat0 : -1;
    nst = int'(v0 && b0 != 0) + int'(v1 && b1 != 0);
    e0 = exp_res(s0, r0, a0, b0);
    e1 = exp_res(s1, r1, a1, b1);
    req0_valid = v0; req1_valid = v1; req0_signed = s0; req1_signed = s1; req0_rem = r0; req1_rem = r1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1; req0_rd = d0; req1_rd = d1;
    #1;
    t = cyc;
    s0n = starts;
    bad = stall_divider ? 0 : 1;
    st_seen = -1;
    fa = 'x;
    got = 0;
    for (int k = 1; k <= 2 * N + 10; k++) begin
      accept = 1'($urandom % 2);
      step();
      if (div_ready) begin
        got = 1;
        break;
      end
      if (!stall_divider) bad++;
      if (core_start && st_seen < 0) begin
        st_seen = cyc - t;
        fa = core_a;
      end
    end
    accept = 0;
    chk("done_latency", got ? cyc - t : -1, 1 + lat0 + lat1);
    chk("stall_while_busy", bad, 0);
    chk("first_start_cycle", st_seen, st_exp);
    if (st_exp >= 0) chk("start_lane_a", fa, (v0 && b0 != 0) ? a0 : a1);
    chk("res0_valid", res0_valid, v0);
    chk("res1_valid", res1_valid, v1);
    if (v0) begin
      chk("res0_data", res0_data, e0);
      chk("res0_rd", res0_rd, d0);
    end
    if (v1) begin
      chk("res1_data", res1_data, e1);
      chk("res1_rd", res1_rd, d1);
    end
    for (int k = 0; k < hold; k++) begin
      req0_valid = 1'($urandom % 2); req1_valid = 1'($urandom % 2);
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom;
      step();
      chk("hold_ready", div_ready, 1);
      chk("hold_stall", stall_divider, 0);
      chk("hold_start", core_start, 0);
      if (v0) chk("hold_res0", res0_data, e0);
      if (v1) chk("hold_res1", res1_data, e1);
    end
    req0_valid = 0; req1_valid = 0;
    accept = 1;
    step();
    accept = 0;
    #1;
    chk("starts", starts - s0n, nst);
    chk("idle_ready", div_ready, 0);
    chk("idle_res_valid", {res0_valid, res1_valid}, 0);
    chk("idle_stall", stall_divider, 0);
  endtask

  initial begin
    logic v0, v1, s0, s1, r0, r1;
    logic [31:0] a0, b0, a1, b1;
    int t;
    repeat (3) step();
    chk("rst_outputs", {core_start, core_abort, stall_divider, div_ready, res0_valid, res1_valid}, 0);
    chk("rst_data", res0_data | res1_data | core_a | core_b, 0);
    aresetn = 1;
    step();
    txn(1, 0, 1, 0, 0, 0, 100, 7, 0, 0, 5'd9, 5'd0, 0);
    txn(1, 1, 0, 1, 1, 0, 100, 7, -32'sd20, 3, 5'd3, 5'd17, 2);
    txn(1, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 5'd1, 5'd0, 1);
    txn(0, 1, 1, 1, 0, 1, 0, 0, -32'sd7, 0, 5'd0, 5'd30, 5);
    // flush mid-RUN0
    req0_valid = 1; req0_signed = 0; req0_rem = 0; req0_a = 1000; req0_b = 3; req1_valid = 0;
    #1;
    t = cyc;
    repeat (10) step();
    flush = 1;
    #1;
    chk("flush_cycle", cyc - t, 10);
    chk("flush_abort", core_abort, 1);
    step();
    flush = 0; req0_valid = 0;
    #1;
    chk("flush_abort_pulse", core_abort, 0);
    chk("flush_idle", {stall_divider, div_ready, res0_valid}, 0);
    inj = 1;
    step();
    inj = 0;
    #1;
    chk("late_done_ignored", {stall_divider, div_ready, res0_valid, core_start}, 0);
    txn(1, 0, 1, 0, 1, 0, -32'sd1001, 10, 0, 0, 5'd12, 5'd0, 0);
    // reset during RUN1
    req0_valid = 1; req0_b = 0; req0_a = 55; req1_valid = 1; req1_a = 77; req1_b = 5;
    repeat (6) step();
    chk("mid_run1_stall", stall_divider, 1);
    aresetn = 0;
    #1;
    chk("reset_no_abort", core_abort, 0);
    step();
    aresetn = 1; req0_valid = 0; req1_valid = 0;
    #1;
    chk("rst_mid_ctl", {core_start, core_abort, core_signed, stall_divider, div_ready, res0_valid, res1_valid}, 0);
    chk("rst_mid_data", res0_data | res1_data | core_a | core_b, 0);
    chk("rst_mid_rd", {res0_rd, res1_rd}, 0);
    step();
    for (int n = 0; n < 20; n++) begin
      v0 = 1'($urandom % 2); v1 = 1'($urandom % 2);
      if (!v0 && !v1) v1 = 1;
      s0 = 1'($urandom % 2); s1 = 1'($urandom % 2); r0 = 1'($urandom % 2); r1 = 1'($urandom % 2);
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom % 4 == 0) ? 0 : ($urandom % 2) ? $urandom % 50 + 1 : $urandom;
      b1 = ($urandom % 4 == 0) ? 0 : ($urandom % 2) ? -($urandom % 50 + 1) : $urandom;
      if (s0 && a0 == 32'h80000000 && b0 == 32'hffffffff) b0 = 1;
      if (s1 && a1 == 32'h80000000 && b1 == 32'hffffffff) b1 = 1;
      txn(v0, v1, s0, s1, r0, r1, a0, b0, a1, b1, 5'($urandom), 5'($urandom), int'($urandom % 4));
    end
    chk("start_while_busy", ovl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
